// File: rtl/ailn_out_collector.sv
// ailn_out_collector: packs the serial normalized element stream into one
// wide vector and hands it downstream under a valid/ready handshake.
module ailn_out_collector #(
  parameter int DATA_WIDTH = 192,
  parameter int ELEM_WIDTH = 8,
  localparam int N_ELEM = DATA_WIDTH / ELEM_WIDTH,
  localparam int CNT_W = $clog2(N_ELEM + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_valid,
  input  logic [ELEM_WIDTH-1:0] i_data,
  input  logic                  i_done,
  input  logic                  i_vec_ready,
  output logic [DATA_WIDTH-1:0] o_vec,
  output logic                  o_vec_valid,
  output logic                  o_busy,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_err_short,
  output logic                  o_err_over
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t state;
  logic   arm;
  logic   last;

  // A held vector is only abandoned once it has been handed off.
  always_comb begin
    arm = 1'b0;
    unique case (1'b1)
      state == IDLE:    arm = i_start;
      state == COLLECT: arm = i_start;
      state == HOLD:    arm = i_start & i_vec_ready;
      default:          arm = 1'b0;
    endcase
  end

  assign last = i_valid && (o_count == CNT_W'(N_ELEM - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      o_vec       <= '0;
      o_vec_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_count     <= '0;
      o_err_short <= 1'b0;
      o_err_over  <= 1'b0;
    end else if (arm) begin
      state       <= COLLECT;
      o_vec       <= '0;
      o_vec_valid <= 1'b0;
      o_busy      <= 1'b1;
      o_count     <= '0;
      o_err_short <= 1'b0;
      o_err_over  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) o_err_over <= 1'b1;
        end
        COLLECT: begin
          if (i_valid) begin
            for (int k = 0; k < N_ELEM; k++) begin
              if (o_count == CNT_W'(k))
                o_vec[DATA_WIDTH-1-ELEM_WIDTH*k -: ELEM_WIDTH] <= i_data;
            end
            o_count <= o_count + CNT_W'(1);
          end
          if (last) begin
            state       <= HOLD;
            o_busy      <= 1'b0;
            o_vec_valid <= 1'b1;
          end else if (i_done) begin
            state       <= HOLD;
            o_busy      <= 1'b0;
            o_vec_valid <= 1'b1;
            o_err_short <= 1'b1;
          end
        end
        HOLD: begin
          if (i_valid) o_err_over <= 1'b1;
          if (i_vec_ready) begin
            state       <= IDLE;
            o_vec_valid <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          o_vec_valid <= 1'b0;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ailn_out_collector.sv
// tb_ailn_out_collector: randomized and directed checks of the collector
// against a queue-based model of the collected elements.
module tb_ailn_out_collector;
  localparam int DW = 192;
  localparam int EW = 8;
  localparam int N  = DW / EW;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_start = 1'b0;
  logic          i_valid = 1'b0;
  logic [EW-1:0] i_data = '0;
  logic          i_done = 1'b0;
  logic          i_vec_ready = 1'b0;
  logic [DW-1:0] o_vec;
  logic          o_vec_valid;
  logic          o_busy;
  logic [CW-1:0] o_count;
  logic          o_err_short;
  logic          o_err_over;

  int checks = 0;
  int failures = 0;

  byte unsigned m_q[$];
  bit m_col, m_hold, m_es, m_eo;

  always #5 clk = ~clk;

  ailn_out_collector dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
    .i_valid(i_valid), .i_data(i_data), .i_done(i_done),
    .i_vec_ready(i_vec_ready), .o_vec(o_vec),
    .o_vec_valid(o_vec_valid), .o_busy(o_busy),
    .o_count(o_count), .o_err_short(o_err_short),
    .o_err_over(o_err_over)
  );

  function automatic logic [DW-1:0] m_vec();
    logic [DW-1:0] v = '0;
    for (int i = 0; i < m_q.size(); i++)
      v[DW-1-8*i -: 8] = m_q[i];
    return v;
  endfunction

  function automatic logic [DW+4+CW-1:0] m_all();
    return {m_vec(), m_hold, m_col, CW'(m_q.size()), m_es, m_eo};
  endfunction

  function automatic logic [DW+4+CW-1:0] d_all();
    return {o_vec, o_vec_valid, o_busy, o_count, o_err_short, o_err_over};
  endfunction

  function automatic void m_step(bit rst, st, vl, byte unsigned d,
                                 bit dn, rd);
    if (rst) begin
      m_q.delete();
      m_col = 0; m_hold = 0; m_es = 0; m_eo = 0;
    end else if (st && !(m_hold && !rd)) begin
      m_q.delete();
      m_col = 1; m_hold = 0; m_es = 0; m_eo = 0;
    end else if (m_col) begin
      if (vl) m_q.push_back(d);
      if (m_q.size() == N || dn) begin
        m_es = (m_q.size() < N);
        m_col = 0;
        m_hold = 1;
      end
    end else begin
      if (vl) m_eo = 1;
      if (m_hold && rd) m_hold = 0;
    end
  endfunction

  task automatic cyc(input bit rst, st, vl, input logic [7:0] d,
                     input bit dn, rd);
    i_rst = rst; i_start = st; i_valid = vl;
    i_data = d; i_done = dn; i_vec_ready = rd;
    @(posedge clk);
    m_step(rst, st, vl, d, dn, rd);
    #1;
    i_start = 0; i_valid = 0; i_done = 0; i_vec_ready = 0; i_rst = 0;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    checks++;
    if (d_all() !== '0) begin
      failures++;
      $display("FAIL reset_init got=%h exp=0", d_all());
    end
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'($urandom), 0, 0);
    checks++;
    if (o_count !== CW'(5)) begin
      failures++;
      $display("FAIL reset_precount got=%0d exp=5", o_count);
    end
    cyc(1, 0, 1, 8'h55, 0, 1);
    cyc(1, 1, 0, 0, 1, 0);
    checks++;
    if (d_all() !== '0) begin
      failures++;
      $display("FAIL reset_mid got=%h exp=0", d_all());
    end
    cyc(0, 0, 0, 0, 0, 0);
    checks++;
    if (o_busy !== 1'b0 || o_vec_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy=%b valid=%b exp=0,0",
               o_busy, o_vec_valid);
    end
  endtask

  task automatic test_full();
    logic [DW-1:0] pat;
    pat = 192'h7C638B2F_E1104AD3_5B96C207_3EF18A64_19B7D25E_A04895CD;
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) begin
        checks++;
        if (o_vec_valid !== 1'b0) begin
          failures++;
          $display("FAIL full_early_valid got=%b exp=0", o_vec_valid);
        end
      end
      cyc(0, 0, 1, pat[DW-1-8*i -: 8], 0, 0);
    end
    checks++;
    if (o_vec !== pat) begin
      failures++;
      $display("FAIL full_vec got=%h exp=%h", o_vec, pat);
    end
    checks++;
    if (o_vec_valid !== 1'b1 || o_count !== CW'(N)) begin
      failures++;
      $display("FAIL full_valid valid=%b count=%0d exp=1,24",
               o_vec_valid, o_count);
    end
    checks++;
    if (o_err_short !== 1'b0 || o_err_over !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL full_flags short=%b over=%b busy=%b exp=0,0,0",
               o_err_short, o_err_over, o_busy);
    end
    cyc(0, 0, 0, 0, 0, 1);
    checks++;
    if (o_vec_valid !== 1'b0 || o_vec !== pat) begin
      failures++;
      $display("FAIL full_xfer valid=%b vec=%h exp=0,%h",
               o_vec_valid, o_vec, pat);
    end
  endtask

  task automatic test_gapped();
    logic [DW-1:0] held;
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3 * N; i++)
      cyc(0, 0, (i % 3 == 2), 8'($urandom), 0, 0);
    held = m_vec();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (o_vec !== held || o_vec_valid !== 1'b1) begin
        failures++;
        $display("FAIL gapped_hold%0d vec=%h valid=%b exp=%h,1",
                 i, o_vec, o_vec_valid, held);
      end
      cyc(0, i == 4, 0, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 0, 1);
    checks++;
    if (o_vec_valid !== 1'b0 || d_all() !== m_all()) begin
      failures++;
      $display("FAIL gapped_release got=%h exp=%h", d_all(), m_all());
    end
  endtask

  task automatic test_short();
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) cyc(0, 0, 1, 8'(i), 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    checks++;
    if (o_err_short !== 1'b1 || o_count !== CW'(10) || o_vec_valid !== 1'b1) begin
      failures++;
      $display("FAIL short_flags short=%b count=%0d valid=%b exp=1,10,1",
               o_err_short, o_count, o_vec_valid);
    end
    checks++;
    if (o_vec[191:112] !== 80'h0102030405060708090A || o_vec[111:0] !== '0) begin
      failures++;
      $display("FAIL short_vec got=%h", o_vec);
    end
    cyc(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_overflow();
    logic [DW-1:0] held;
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) cyc(0, 0, 1, 8'($urandom), 0, 0);
    held = o_vec;
    cyc(0, 0, 1, 8'hFF, 0, 0);
    checks++;
    if (o_err_over !== 1'b1 || o_vec !== held || o_vec_valid !== 1'b1) begin
      failures++;
      $display("FAIL over_hold over=%b valid=%b vec=%h exp=1,1,%h",
               o_err_over, o_vec_valid, o_vec, held);
    end
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0);
    checks++;
    if (o_err_over !== 1'b0 || o_busy !== 1'b1 || o_vec !== '0) begin
      failures++;
      $display("FAIL over_clear over=%b busy=%b exp=0,1", o_err_over, o_busy);
    end
  endtask

  task automatic test_restart();
    logic [DW-1:0] exp_v;
    exp_v = {N{8'h80}};
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 8'($urandom), 0, 0);
    checks++;
    if (o_count !== CW'(7)) begin
      failures++;
      $display("FAIL restart_pre count=%0d exp=7", o_count);
    end
    cyc(0, 1, 1, 8'h11, 0, 0);
    checks++;
    if (o_count !== '0 || o_vec !== '0 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_clear count=%0d vec=%h busy=%b",
               o_count, o_vec, o_busy);
    end
    for (int i = 0; i < N; i++) cyc(0, 0, 1, 8'h80, 0, 0);
    checks++;
    if (o_vec !== exp_v || o_err_short || o_err_over || !o_vec_valid) begin
      failures++;
      $display("FAIL restart_vec got=%h short=%b over=%b valid=%b",
               o_vec, o_err_short, o_err_over, o_vec_valid);
    end
    cyc(0, 1, 0, 0, 0, 1);
    checks++;
    if (d_all() !== m_all() || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_b2b got=%h exp=%h", d_all(), m_all());
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 14) == 0,
          $urandom_range(0, 1) == 1, 8'($urandom),
          $urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0);
      checks++;
      if (d_all() !== m_all()) begin
        failures++;
        errs++;
        if (errs <= 5)
          $display("FAIL random_c%0d got=%h exp=%h", i, d_all(), m_all());
      end
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_gapped();
    test_short();
    test_overflow();
    test_restart();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
